// File: rtl/frac_clk_div_if.sv
// Configuration and status bundle of the fractional clock divider.
// The requester owns en/div/half/load; the divider owns clk_out and the status pulses.
interface frac_clk_div_if #(
  parameter int W = 8
);
  logic         en;
  logic [W-1:0] div;
  logic         half;
  logic         load;
  logic         clk_out;
  logic         tick;
  logic         ack;
  logic         err;

  modport master (output en, div, half, load, input clk_out, tick, ack, err);
  modport slave  (input en, div, half, load, output clk_out, tick, ack, err);
endinterface

// File: rtl/frac_clk_div.sv
// Divide-by-N / N+0.5 clock generator with ~50% duty and boundary-aligned reconfiguration.
// CLK_OUT follows the sampled edge directly; TICK/ACK are rising-edge registered, no backpressure.
module frac_clk_div #(
  parameter int W            = 8,
  parameter int DEFAULT_DIV  = 5,
  parameter int DEFAULT_HALF = 0
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  frac_clk_div_if.slave bus
);
  typedef struct packed { logic ph; logic [W-1:0] c; } pos_t;
  typedef struct packed { logic [W-1:0] n; logic h; } cfg_t;
  typedef struct packed { logic wrap; pos_t p; } stp_t;

  localparam cfg_t CFG_DEF = '{n: W'(DEFAULT_DIV), h: (DEFAULT_HALF != 0)};

  // Position is (phase, index within phase): high phase lasts n hc, low phase n or n+1 hc,
  // so a W-bit index never has to hold more than n.
  function automatic stp_t step(input pos_t p, input cfg_t k);
    stp_t         s;
    logic [W-1:0] last;
    last   = (p.ph && k.h) ? k.n : (k.n - W'(1));
    s.wrap = 1'b0;
    s.p    = p;
    if (p.c == last) begin
      s.p.c  = '0;
      s.p.ph = ~p.ph;
      s.wrap = p.ph;
    end else begin
      s.p.c = p.c + W'(1);
    end
    return s;
  endfunction

  logic bnd_q, bnd_d;
  pos_t pos_q, pos_d;
  cfg_t act_q, act_d, shd_q, shd_d;
  logic pend_q, pend_d, err_q, err_d;
  logic tick_q, tick_d, ack_q, ack_d;
  logic tick_late_q, tick_late_d, ack_late_q, ack_late_d;
  logic r_q, r_d, fnext_q, fnext_d, f_q;

  pos_t pos_e, pos_1;
  cfg_t cfg_e, cfg_1;
  stp_t s1, s2;
  logic run_e, run_1, v_e, v_1;
  logic start_e, start_1, app_e, app_1;
  logic legal, load_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bnd_q       <= 1'b1;
      pos_q       <= '0;
      act_q       <= CFG_DEF;
      shd_q       <= CFG_DEF;
      pend_q      <= 1'b0;
      err_q       <= 1'b0;
      tick_q      <= 1'b0;
      ack_q       <= 1'b0;
      tick_late_q <= 1'b0;
      ack_late_q  <= 1'b0;
      r_q         <= 1'b0;
      fnext_q     <= 1'b1;
    end else begin
      bnd_q       <= bnd_d;
      pos_q       <= pos_d;
      act_q       <= act_d;
      shd_q       <= shd_d;
      pend_q      <= pend_d;
      err_q       <= err_d;
      tick_q      <= tick_d;
      ack_q       <= ack_d;
      tick_late_q <= tick_late_d;
      ack_late_q  <= ack_late_d;
      r_q         <= r_d;
      fnext_q     <= fnext_d;
    end
  end

  // Idles high: while stopped r_q alone holds the output low, and a start needs no falling edge.
  always_ff @(negedge clk_i or negedge rst_ni) begin
    if (!rst_ni) f_q <= 1'b1;
    else         f_q <= fnext_q;
  end

  // Each rising edge resolves hc e and hc e+1, and looks ahead to hc e+2 for the falling flop.
  always_comb begin
    legal   = (bus.div >= W'(2)) || ((bus.div == W'(1)) && bus.half);
    load_ok = bus.load && legal;

    cfg_e   = act_q;
    pos_e   = pos_q;
    run_e   = 1'b1;
    v_e     = ~pos_q.ph;
    start_e = 1'b0;
    app_e   = 1'b0;
    if (bnd_q) begin
      pos_e   = '0;
      run_e   = bus.en;
      v_e     = bus.en;
      start_e = bus.en;
      app_e   = bus.en && pend_q;
      if (app_e) cfg_e = shd_q;
    end

    s1      = step(pos_e, cfg_e);
    cfg_1   = cfg_e;
    pos_1   = s1.p;
    run_1   = run_e;
    start_1 = 1'b0;
    app_1   = 1'b0;
    if (run_e && s1.wrap) begin
      run_1   = bus.en;
      start_1 = bus.en;
      app_1   = bus.en && pend_q;
      if (app_1) cfg_1 = shd_q;
    end
    v_1 = run_1 && !pos_1.ph;

    s2    = step(pos_1, cfg_1);
    bnd_d = !run_1 || s2.wrap;
    pos_d = bnd_d ? '0 : s2.p;

    // A flop is high when either hc it spans is high; low phases of >= 2 hc keep the AND exact.
    r_d     = v_e || v_1;
    fnext_d = v_1 || bnd_d || !s2.p.ph;

    act_d       = cfg_1;
    shd_d       = load_ok ? '{n: bus.div, h: bus.half} : shd_q;
    pend_d      = load_ok || (pend_q && !(app_e || app_1));
    err_d       = bus.load ? !legal : err_q;
    tick_d      = start_e || tick_late_q;
    ack_d       = app_e || ack_late_q;
    tick_late_d = start_1;
    ack_late_d  = app_1;
  end

  assign bus.clk_out = r_q & f_q;
  assign bus.tick    = tick_q;
  assign bus.ack     = ack_q;
  assign bus.err     = err_q;
endmodule
